// File: rtl/univ_sh_rgst.sv
// Universal shift register: parallel load, logical/arithmetic shifts and
// rotates in both directions. It also has a self-timed burst engine that
// shifts a latched count of positions, one bit per cycle, with a
// busy/done handshake.
module univ_sh_rgst #(
    parameter int W  = 8,
    parameter int AW = $clog2(W) + 1
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic [W-1:0]  d,
    input  logic [2:0]    op,
    input  logic          sin_r,
    input  logic          sin_l,
    input  logic          start,
    input  logic [AW-1:0] amt,
    input  logic          dir,
    output logic [W-1:0]  q,
    output logic          sout_r,
    output logic          sout_l,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BURST = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    localparam logic [2:0]    OP_HOLD = 3'b000;
    localparam logic [2:0]    OP_LOAD = 3'b001;
    localparam logic [2:0]    OP_SHR  = 3'b010;
    localparam logic [2:0]    OP_SHL  = 3'b011;
    localparam logic [2:0]    OP_ROR  = 3'b100;
    localparam logic [2:0]    OP_ROL  = 3'b101;
    localparam logic [2:0]    OP_ASHR = 3'b110;

    localparam logic [AW-1:0] REM_MAX  = AW'(W);
    localparam logic [AW-1:0] REM_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0] REM_ONE  = {{(AW-1){1'b0}}, 1'b1};

    state_t        state_r;
    state_t        state_nxt_s;
    logic [AW-1:0] rem_r;
    logic [AW-1:0] rem_nxt_s;
    logic          dir_r;
    logic          dir_nxt_s;
    logic [W-1:0]  q_r;
    logic [W-1:0]  q_nxt_s;
    logic          sout_rgt_r;
    logic          sout_rgt_nxt_s;
    logic          sout_lft_r;
    logic          sout_lft_nxt_s;
    logic          busy_r;
    logic          busy_nxt_s;
    logic          done_r;
    logic          done_nxt_s;
    logic [AW-1:0] amt_clamp_s;
    logic          start_take_s;
    logic          op_take_s;

    // Saturate the requested burst length at the register width.
    assign amt_clamp_s  = (amt > REM_MAX) ? REM_MAX : amt;
    // start is only accepted in IDLE and then overrides op for that cycle.
    assign start_take_s = (state_r == ST_IDLE) && start;
    // Single-cycle ops are honoured in IDLE (without start) and in DONE.
    assign op_take_s    = ((state_r == ST_IDLE) && !start) || (state_r == ST_DONE);

    // State register.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic of the burst FSM.
    always_comb begin
        state_nxt_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (amt_clamp_s == REM_ZERO) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_BURST;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BURST: begin
                // <= instead of == so a corrupted zero count cannot trap the FSM.
                if (rem_r <= REM_ONE) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_BURST;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state so busy/done come straight from flops.
    always_comb begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
        case (state_nxt_s)
            ST_BURST: begin
                busy_nxt_s = 1'b1;
                done_nxt_s = 1'b0;
            end
            ST_DONE: begin
                busy_nxt_s = 1'b0;
                done_nxt_s = 1'b1;
            end
            default: begin
                busy_nxt_s = 1'b0;
                done_nxt_s = 1'b0;
            end
        endcase
    end

    // Datapath: single-cycle ops, burst shifts and burst parameter capture.
    always_comb begin
        q_nxt_s        = q_r;
        sout_rgt_nxt_s = sout_rgt_r;
        sout_lft_nxt_s = sout_lft_r;
        rem_nxt_s      = rem_r;
        dir_nxt_s      = dir_r;
        if (start_take_s) begin
            rem_nxt_s = amt_clamp_s;
            dir_nxt_s = dir;
        end else if (state_r == ST_BURST) begin
            if (dir_r) begin
                q_nxt_s        = {q_r[W-2:0], sin_l};
                sout_lft_nxt_s = q_r[W-1];
            end else begin
                q_nxt_s        = {sin_r, q_r[W-1:1]};
                sout_rgt_nxt_s = q_r[0];
            end
            if (rem_r != REM_ZERO) begin
                rem_nxt_s = rem_r - REM_ONE;
            end else begin
                rem_nxt_s = REM_ZERO;
            end
        end else if (op_take_s) begin
            case (op)
                OP_HOLD: begin
                    q_nxt_s = q_r;
                end
                OP_LOAD: begin
                    q_nxt_s = d;
                end
                OP_SHR: begin
                    q_nxt_s        = {sin_r, q_r[W-1:1]};
                    sout_rgt_nxt_s = q_r[0];
                end
                OP_SHL: begin
                    q_nxt_s        = {q_r[W-2:0], sin_l};
                    sout_lft_nxt_s = q_r[W-1];
                end
                OP_ROR: begin
                    q_nxt_s        = {q_r[0], q_r[W-1:1]};
                    sout_rgt_nxt_s = q_r[0];
                end
                OP_ROL: begin
                    q_nxt_s        = {q_r[W-2:0], q_r[W-1]};
                    sout_lft_nxt_s = q_r[W-1];
                end
                OP_ASHR: begin
                    q_nxt_s        = {q_r[W-1], q_r[W-1:1]};
                    sout_rgt_nxt_s = q_r[0];
                end
                default: begin
                    q_nxt_s = q_r;
                end
            endcase
        end else begin
            q_nxt_s = q_r;
        end
    end

    // Datapath and handshake registers.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            q_r        <= {W{1'b0}};
            sout_rgt_r <= 1'b0;
            sout_lft_r <= 1'b0;
            rem_r      <= REM_ZERO;
            dir_r      <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            q_r        <= q_nxt_s;
            sout_rgt_r <= sout_rgt_nxt_s;
            sout_lft_r <= sout_lft_nxt_s;
            rem_r      <= rem_nxt_s;
            dir_r      <= dir_nxt_s;
            busy_r     <= busy_nxt_s;
            done_r     <= done_nxt_s;
        end
    end

    assign q      = q_r;
    assign sout_r = sout_rgt_r;
    assign sout_l = sout_lft_r;
    assign busy   = busy_r;
    assign done   = done_r;

endmodule

// File: tb/tb_univ_sh_rgst.sv
// Self-checking bench for univ_sh_rgst (W=8). A reference model pushes the
// expected post-edge outputs onto a scoreboard queue as each cycle is driven;
// every test task pops and compares once the DUT has clocked.
module tb_univ_sh_rgst;

    localparam int W  = 8;
    localparam int AW = $clog2(W) + 1;

    typedef struct packed {
        logic [W-1:0] q;
        logic         sr;
        logic         sl;
        logic         busy;
        logic         done;
    } exp_t;

    logic          clk;
    logic          rst_b;
    logic [W-1:0]  d;
    logic [2:0]    op;
    logic          sin_r;
    logic          sin_l;
    logic          start;
    logic [AW-1:0] amt;
    logic          dir;
    logic [W-1:0]  q;
    logic          sout_r;
    logic          sout_l;
    logic          busy;
    logic          done;

    exp_t sb[$];
    exp_t e;
    int   checks;
    int   errors;

    int           m_st;
    logic [3:0]   m_rem;
    logic         m_dir;
    logic [W-1:0] m_q;
    logic         m_sr;
    logic         m_sl;

    univ_sh_rgst #(.W(W), .AW(AW)) dut (
        .clk(clk), .rst_b(rst_b), .d(d), .op(op), .sin_r(sin_r), .sin_l(sin_l),
        .start(start), .amt(amt), .dir(dir), .q(q), .sout_r(sout_r),
        .sout_l(sout_l), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_st = 0; m_rem = 4'd0; m_dir = 1'b0; m_q = 8'h00; m_sr = 1'b0; m_sl = 1'b0;
        sb.delete();
    endtask

    // Drive one cycle of stimulus, push the model's expectation, clock it.
    task automatic cycle(input logic [2:0] o, input logic [7:0] dd, input logic s_r,
                         input logic s_l, input logic st, input logic [3:0] a, input logic dr);
        exp_t x;
        op = o; d = dd; sin_r = s_r; sin_l = s_l; start = st; amt = a; dir = dr;
        if (m_st == 1) begin
            if (m_dir) begin m_sl = m_q[7]; m_q = {m_q[6:0], s_l}; end
            else       begin m_sr = m_q[0]; m_q = {s_r, m_q[7:1]}; end
            m_rem = m_rem - 4'd1;
            m_st  = (m_rem == 4'd0) ? 2 : 1;
        end else if (m_st == 0 && st) begin
            m_rem = (a > 4'd8) ? 4'd8 : a;
            m_dir = dr;
            m_st  = (m_rem == 4'd0) ? 2 : 1;
        end else begin
            case (o)
                3'd1: m_q = dd;
                3'd2: begin m_sr = m_q[0]; m_q = {s_r, m_q[7:1]}; end
                3'd3: begin m_sl = m_q[7]; m_q = {m_q[6:0], s_l}; end
                3'd4: begin m_sr = m_q[0]; m_q = {m_q[0], m_q[7:1]}; end
                3'd5: begin m_sl = m_q[7]; m_q = {m_q[6:0], m_q[7]}; end
                3'd6: begin m_sr = m_q[0]; m_q = {m_q[7], m_q[7:1]}; end
                default: m_q = m_q;
            endcase
            m_st = 0;
        end
        x.q = m_q; x.sr = m_sr; x.sl = m_sl; x.busy = (m_st == 1); x.done = (m_st == 2);
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        op = 3'd0; d = 8'h00; sin_r = 1'b0; sin_l = 1'b0; start = 1'b0; amt = 4'd0; dir = 1'b0;
        rst_b = 1'b0;
        model_reset();
        @(posedge clk); #1;
        checks++;
        if ({q, sout_r, sout_l, busy, done} !== 12'h000) begin
            errors++; $display("FAIL reset_init: got q=%h sr=%b sl=%b busy=%b done=%b, expected all 0", q, sout_r, sout_l, busy, done);
        end
        rst_b = 1'b1;
        cycle(3'd1, 8'h5A, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        e = sb.pop_front(); checks++;
        if ({q, sout_r, sout_l, busy, done} !== e || q !== 8'h5A) begin
            errors++; $display("FAIL reset_load: got q=%h, expected %h", q, e.q);
        end
        #2 rst_b = 1'b0;
        #1;
        checks++;
        if ({q, sout_r, sout_l, busy, done} !== 12'h000) begin
            errors++; $display("FAIL reset_async: got q=%h sr=%b sl=%b busy=%b done=%b, expected all 0", q, sout_r, sout_l, busy, done);
        end
        model_reset();
        @(posedge clk); #1;
        rst_b = 1'b1;
    endtask

    task automatic test_load_shift();
        logic [7:0] exp_q [3] = '{8'hA5, 8'hD2, 8'hA4};
        logic [2:0] ops   [3] = '{3'd1, 3'd2, 3'd3};
        logic       s_r   [3] = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            cycle(ops[i], 8'hA5, s_r[i], 1'b0, 1'b0, 4'd0, 1'b0);
            e = sb.pop_front(); checks++;
            if ({q, sout_r, sout_l, busy, done} !== e || q !== exp_q[i]) begin
                errors++; $display("FAIL load_shift[%0d]: got q=%h sr=%b sl=%b, expected q=%h sr=%b sl=%b", i, q, sout_r, sout_l, exp_q[i], e.sr, e.sl);
            end
        end
        checks++;
        if (sout_r !== 1'b1 || sout_l !== 1'b1) begin
            errors++; $display("FAIL serial_outs: got sr=%b sl=%b, expected sr=1 sl=1", sout_r, sout_l);
        end
    endtask

    task automatic test_rotate_ashr();
        logic [2:0] ops   [6] = '{3'd1, 3'd4, 3'd5, 3'd1, 3'd6, 3'd7};
        logic [7:0] dd    [6] = '{8'h81, 8'h00, 8'h00, 8'h80, 8'h00, 8'h33};
        logic [7:0] exp_q [6] = '{8'h81, 8'hC0, 8'h81, 8'h80, 8'hC0, 8'hC0};
        for (int i = 0; i < 6; i++) begin
            cycle(ops[i], dd[i], 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
            e = sb.pop_front(); checks++;
            if ({q, sout_r, sout_l, busy, done} !== e || q !== exp_q[i]) begin
                errors++; $display("FAIL rot_ashr[%0d]: got q=%h sr=%b sl=%b, expected q=%h sr=%b sl=%b", i, q, sout_r, sout_l, exp_q[i], e.sr, e.sl);
            end
            if (i == 1 && sout_r !== 1'b1) begin
                errors++; $display("FAIL ror_sout: got %b, expected 1", sout_r);
            end
            if (i == 2 && sout_l !== 1'b1) begin
                errors++; $display("FAIL rol_sout: got %b, expected 1", sout_l);
            end
            if (i == 4 && sout_r !== 1'b0) begin
                errors++; $display("FAIL ashr_sout: got %b, expected 0", sout_r);
            end
        end
    endtask

    task automatic test_burst_right();
        logic [7:0] exp_q [5] = '{8'hF0, 8'h78, 8'h3C, 8'h1E, 8'h1E};
        logic [1:0] exp_hs[5] = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b00};
        cycle(3'd1, 8'hF0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        e = sb.pop_front(); checks++;
        if ({q, sout_r, sout_l, busy, done} !== e) begin
            errors++; $display("FAIL burst_r_load: got q=%h, expected %h", q, e.q);
        end
        for (int i = 0; i < 5; i++) begin
            if (i == 0)      cycle(3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0);
            else if (i < 4)  cycle(3'd1, 8'h00, 1'b0, 1'b0, 1'b1, 4'd5, 1'b1);
            else             cycle(3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
            e = sb.pop_front(); checks++;
            if ({q, sout_r, sout_l, busy, done} !== e || q !== exp_q[i] || {busy, done} !== exp_hs[i]) begin
                errors++; $display("FAIL burst_r[%0d]: got q=%h busy=%b done=%b, expected q=%h busy/done=%b", i, q, busy, done, exp_q[i], exp_hs[i]);
            end
        end
    endtask

    task automatic test_burst_bounds();
        logic [7:0] q0;
        int busy_cnt;
        q0 = q;
        cycle(3'd1, 8'hEE, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
        e = sb.pop_front(); checks++;
        if ({q, sout_r, sout_l, busy, done} !== e || q !== q0 || busy !== 1'b0 || done !== 1'b1) begin
            errors++; $display("FAIL amt0_pulse: got q=%h busy=%b done=%b, expected q=%h busy=0 done=1", q, busy, done, q0);
        end
        cycle(3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        e = sb.pop_front(); checks++;
        if ({q, sout_r, sout_l, busy, done} !== e || done !== 1'b0) begin
            errors++; $display("FAIL amt0_end: got done=%b busy=%b, expected 0 0", done, busy);
        end
        cycle(3'd1, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        void'(sb.pop_front());
        busy_cnt = 0;
        for (int i = 0; i < 9; i++) begin
            if (i == 0) cycle(3'd0, 8'h00, 1'b0, 1'b1, 1'b1, 4'd12, 1'b1);
            else        cycle(3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
            if (busy === 1'b1) busy_cnt++;
            e = sb.pop_front(); checks++;
            if ({q, sout_r, sout_l, busy, done} !== e) begin
                errors++; $display("FAIL clamp[%0d]: got q=%h sl=%b busy=%b done=%b, expected q=%h sl=%b busy=%b done=%b", i, q, sout_l, busy, done, e.q, e.sl, e.busy, e.done);
            end
        end
        checks++;
        if (q !== 8'hFF || sout_l !== 1'b0 || done !== 1'b1 || busy_cnt != 8) begin
            errors++; $display("FAIL clamp_final: got q=%h sl=%b done=%b busy_cycles=%0d, expected FF 0 1 8", q, sout_l, done, busy_cnt);
        end
        cycle(3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        void'(sb.pop_front());
        cycle(3'd1, 8'hAA, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0);
        e = sb.pop_front(); checks++;
        if ({q, sout_r, sout_l, busy, done} !== e || q !== 8'hFF) begin
            errors++; $display("FAIL start_over_op: got q=%h busy=%b, expected q=FF busy=1", q, busy);
        end
        cycle(3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        e = sb.pop_front(); checks++;
        if ({q, sout_r, sout_l, busy, done} !== e || q !== 8'h7F) begin
            errors++; $display("FAIL start_over_op_shift: got q=%h done=%b, expected q=7F done=1", q, done);
        end
    endtask

    task automatic test_reset_mid_burst();
        cycle(3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        void'(sb.pop_front());
        cycle(3'd1, 8'hFF, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        void'(sb.pop_front());
        for (int i = 0; i < 3; i++) begin
            if (i == 0) cycle(3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd6, 1'b0);
            else        cycle(3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
            e = sb.pop_front(); checks++;
            if ({q, sout_r, sout_l, busy, done} !== e) begin
                errors++; $display("FAIL mid_burst[%0d]: got q=%h busy=%b, expected q=%h busy=%b", i, q, busy, e.q, e.busy);
            end
        end
        #2 rst_b = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({q, sout_r, sout_l, busy, done} !== 12'h000) begin
                errors++; $display("FAIL abort[%0d]: got q=%h sr=%b sl=%b busy=%b done=%b, expected all 0", i, q, sout_r, sout_l, busy, done);
            end
            @(posedge clk); #1;
        end
        rst_b = 1'b1;
        cycle(3'd1, 8'h3C, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        e = sb.pop_front(); checks++;
        if ({q, sout_r, sout_l, busy, done} !== e || q !== 8'h3C) begin
            errors++; $display("FAIL post_reset_load: got q=%h done=%b, expected q=3C done=0", q, done);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 300; i++) begin
            cycle(3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 9) == 0), 4'($urandom_range(0, 15)), 1'($urandom));
            e = sb.pop_front(); checks++;
            if ({q, sout_r, sout_l, busy, done} !== e || (busy && done)) begin
                errors++; $display("FAIL random[%0d]: got q=%h sr=%b sl=%b busy=%b done=%b, expected q=%h sr=%b sl=%b busy=%b done=%b",
                                   i, q, sout_r, sout_l, busy, done, e.q, e.sr, e.sl, e.busy, e.done);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_load_shift();
        test_rotate_ashr();
        test_burst_right();
        test_burst_bounds();
        test_reset_mid_burst();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
